// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle shared by the pipeline and the branch predictor.
// The pipeline side is the master: it presents the fetch PC and the
// decode-stage resolution, and consumes the prediction and flush request.
interface branch_predictor_if #(
    parameter int CNT_BITS = 32
);
    logic [31:0]         fetch_pc;
    logic                predict_taken;
    logic [31:0]         predict_target;
    logic                resolve_valid;
    logic [31:0]         resolve_pc;
    logic [2:0]          resolve_variant;
    logic                resolve_taken;
    logic [31:0]         resolve_target;
    logic                resolve_pred_taken;
    logic [31:0]         resolve_pred_target;
    logic                mispredict;
    logic [CNT_BITS-1:0] mispredict_count;

    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_variant,
               resolve_taken, resolve_target, resolve_pred_taken,
               resolve_pred_target,
        input  predict_taken, predict_target, mispredict, mispredict_count
    );

    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_variant,
               resolve_taken, resolve_target, resolve_pred_taken,
               resolve_pred_target,
        output predict_taken, predict_target, mispredict, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating
// counters plus a circular return-address stack. Lookup is combinational on
// pre-edge state; training comes from the decode-stage resolution.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int RAS_DEPTH  = 4,
    parameter int CNT_BITS   = 32
) (
    input logic              clock,
    input logic              reset,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;
    localparam int PTR_W   = $clog2(RAS_DEPTH);

    typedef enum logic [2:0] {
        BV_NONE      = 3'd0,
        BV_JUMP      = 3'd1,
        BV_JUMP_REG  = 3'd2,
        BV_JUMP_LINK = 3'd3,
        BV_BEQ       = 3'd4,
        BV_BNE       = 3'd5,
        BV_BLTZ      = 3'd6
    } variant_e;

    // BTB storage; only the valid bits are reset
    logic [ENTRIES-1:0] btb_valid;
    logic [ENTRIES-1:0] btb_ret;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [31:0]        btb_target [ENTRIES];
    logic [1:0]         btb_ctr    [ENTRIES];

    // RAS: ras_ptr is the next write slot, top of stack sits at ras_ptr-1
    logic [31:0]        ras_data [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;
    logic [PTR_W:0]     ras_count;
    logic [PTR_W-1:0]   ras_top_ptr;

    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic [TAG_W-1:0]      f_tag, r_tag;
    logic                  f_hit, r_hit;
    logic                  is_jump, is_cond;
    logic                  alloc, cond_upd, kill, push, pop;
    logic                  unused_pc_bits;

    assign f_idx = bp.fetch_pc[INDEX_BITS+1:2];
    assign f_tag = bp.fetch_pc[31:INDEX_BITS+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign r_idx = bp.resolve_pc[INDEX_BITS+1:2];
    assign r_tag = bp.resolve_pc[31:INDEX_BITS+2];
    assign r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);

    assign unused_pc_bits = ^{bp.fetch_pc[1:0], bp.resolve_pc[1:0]};

    assign ras_top_ptr = ras_ptr - PTR_W'(1);

    assign is_jump = bp.resolve_variant inside {BV_JUMP, BV_JUMP_REG, BV_JUMP_LINK};
    assign is_cond = bp.resolve_variant inside {BV_BEQ, BV_BNE, BV_BLTZ};

    // jumps always (re)write; a taken conditional that misses evicts any alias
    assign alloc    = bp.resolve_valid && (is_jump || (is_cond && !r_hit && bp.resolve_taken));
    assign cond_upd = bp.resolve_valid && is_cond && r_hit;
    // a non-branch that was predicted taken came from a stale entry
    assign kill     = bp.resolve_valid && (bp.resolve_variant == BV_NONE)
                      && bp.resolve_pred_taken && r_hit;
    assign push     = bp.resolve_valid && (bp.resolve_variant == BV_JUMP_LINK);
    assign pop      = bp.resolve_valid && (bp.resolve_variant == BV_JUMP_REG)
                      && (ras_count != '0);

    // fetch-side prediction: returns use the RAS, others the counter MSB
    always_comb begin
        bp.predict_taken  = 1'b0;
        bp.predict_target = bp.fetch_pc + 32'd4;
        if (f_hit && btb_ret[f_idx] && (ras_count != '0)) begin
            bp.predict_taken  = 1'b1;
            bp.predict_target = ras_data[ras_top_ptr];
        end else if (f_hit && btb_ctr[f_idx][1]) begin
            bp.predict_taken  = 1'b1;
            bp.predict_target = btb_target[f_idx];
        end
    end

    // resolution check against the prediction that travelled with the instruction
    always_comb begin
        bp.mispredict = 1'b0;
        if (bp.resolve_valid) begin
            if (bp.resolve_variant == BV_NONE) begin
                bp.mispredict = bp.resolve_pred_taken;
            end else begin
                bp.mispredict = (bp.resolve_pred_taken != bp.resolve_taken)
                                || (bp.resolve_taken
                                    && (bp.resolve_pred_target != bp.resolve_target));
            end
        end
    end

    // BTB valid bits
    always_ff @(posedge clock) begin
        if (reset) begin
            btb_valid <= '0;
        end else if (alloc) begin
            btb_valid[r_idx] <= 1'b1;
        end else if (kill) begin
            btb_valid[r_idx] <= 1'b0;
        end
    end

    // BTB payload: allocation or saturating counter training
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (alloc) begin
                btb_tag[r_idx]    <= r_tag;
                btb_target[r_idx] <= bp.resolve_target;
                btb_ctr[r_idx]    <= is_jump ? 2'b11 : 2'b10;
                btb_ret[r_idx]    <= (bp.resolve_variant == BV_JUMP_REG);
            end else if (cond_upd) begin
                if (bp.resolve_taken) begin
                    btb_target[r_idx] <= bp.resolve_target;
                    if (btb_ctr[r_idx] != 2'b11) begin
                        btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
                    end
                end else if (btb_ctr[r_idx] != 2'b00) begin
                    btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
                end
            end
        end
    end

    // RAS pointer/count; a full push wraps and overwrites the oldest slot
    always_ff @(posedge clock) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_count != (PTR_W+1)'(RAS_DEPTH)) begin
                ras_count <= ras_count + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            ras_ptr   <= ras_ptr - PTR_W'(1);
            ras_count <= ras_count - (PTR_W+1)'(1);
        end
    end

    // RAS data: link address written at the current pointer
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            ras_data[ras_ptr] <= bp.resolve_pc + 32'd4;
        end
    end

    // saturating mispredict statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            bp.mispredict_count <= '0;
        end else if (bp.mispredict && (bp.mispredict_count != '1)) begin
            bp.mispredict_count <= bp.mispredict_count + CNT_BITS'(1);
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised fetch-stage branch predictor, successor to the decode-stage jump resolver.
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters, plus a circular return-address stack (RAS).
- Predicts direction and target for the PC being fetched.
- Trained each cycle from the decode-stage resolution: branch variant, taken flag and actual target.

Parameters:
- INDEX_BITS, 4, log2 of BTB entry count (ENTRIES = 2**INDEX_BITS).
- RAS_DEPTH, 4, number of return-address stack slots (power of 2, >= 2).
- CNT_BITS, 32, width of the mispredict statistics counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  32  PC being fetched this cycle.
- predict_taken  out  1  1 = redirect fetch to predict_target.
- predict_target  out  32  predicted next PC.
- resolve_valid  in  1  decode is presenting a resolved instruction.
- resolve_pc  in  32  PC of the resolved instruction.
- resolve_variant  in  3  BV_* code (BV_NONE, BV_JUMP, BV_JUMP_REG, BV_JUMP_LINK, BV_BEQ, BV_BNE, BV_BLTZ, from mips.h).
- resolve_taken  in  1  actual direction (1 for all jumps).
- resolve_target  in  32  actual target when taken.
- resolve_pred_taken  in  1  prediction that travelled down the pipe with this instruction.
- resolve_pred_target  in  32  predicted target that travelled with it.
- mispredict  out  1  combinational; decode must flush and redirect.
- mispredict_count  out  CNT_BITS  saturating count of mispredicts.

Behaviour:
- BTB entry fields: valid, tag = pc[31:INDEX_BITS+2], target[31:0], ctr[1:0], is_return.
- Index = pc[INDEX_BITS+1:2].
- Lookup (combinational, zero latency):
  - hit = valid and tag match at index(fetch_pc).
  - If hit and is_return and RAS count > 0: predict_taken = 1, predict_target = RAS top.
  - Else if hit and ctr[1] = 1: predict_taken = 1, predict_target = stored target.
  - Otherwise: predict_taken = 0, predict_target = fetch_pc + 4 (mod 2^32).
- Lookup reads pre-edge contents. An update to the same index in the same cycle is visible from the next cycle only; there is no bypass.
- mispredict = resolve_valid and resolve_variant != BV_NONE and (resolve_pred_taken != resolve_taken, or resolve_taken and resolve_pred_target != resolve_target).
  - For BV_NONE, mispredict = resolve_valid and resolve_pred_taken (stale alias hit); such an entry is invalidated on the edge.
- BTB update on rising edge when resolve_valid, indexed by resolve_pc:
  - Jumps (JUMP, JUMP_LINK, JUMP_REG): write valid=1, tag, target=resolve_target, ctr=11, is_return = (variant == BV_JUMP_REG).
  - Conditional branch, hit: ctr saturating +1 if taken, -1 if not; target rewritten if taken.
  - Conditional branch, miss, taken: allocate (overwrites any alias) with ctr=10, is_return=0.
  - Conditional branch, miss, not taken: no write.
- RAS updates on the same edge:
  - BV_JUMP_LINK pushes resolve_pc + 4. When full, the write pointer wraps, the oldest entry is overwritten and count stays RAS_DEPTH.
  - BV_JUMP_REG pops. When count == 0 the pop is ignored (no underflow, pointer unchanged).
  - Only one push or pop per cycle (single resolve port).
- mispredict_count increments on each edge where mispredict = 1; it holds at all-ones.
- Reset: all valid bits = 0, RAS pointer = 0, RAS count = 0, mispredict_count = 0.
  - BTB targets/ctrs and RAS data need no reset.
  - Outputs after reset: predict_taken = 0, predict_target = fetch_pc + 4, mispredict per the inputs.
  - Reset dominates any same-cycle resolve update.
  - Reset mid-training discards all learned state.

Test Plan:
- Reset, fetch_pc=0x00400000 -> predict_taken=0, predict_target=0x00400004, mispredict_count=0.
- BEQ at 0x00400010 resolved taken to 0x00400040, pred_taken=0 -> mispredict=1, count=1. Next cycle fetch 0x00400010 -> taken, target 0x00400040 (ctr=10).
- Same BEQ resolved not-taken twice -> ctr 10→01→00. Fetch predicts not-taken, target 0x00400014; ctr saturates at 00 on a third not-taken.
- JAL at 0x00400100 (push 0x00400104), then JR at 0x00400200 trained -> fetch 0x00400200 predicts 0x00400104. Five pushes with RAS_DEPTH=4 -> four pops return the last four in LIFO order; a fifth pop is ignored.
- Aliasing: branch at 0x00400010 and 0x00400050 (INDEX_BITS=4, same index) -> the second allocation evicts the first; fetch 0x00400010 misses.
- Resolve update and reset asserted together -> all entries invalid afterwards; a resolve on the same edge as lookup of the same PC is not visible until the next cycle.
